// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the next-PC select mux, the hazard unit and pc_redirect_ctrl.
package pc_redirect_ctrl_pkg;

    localparam logic [2:0] PCSEL_SEQ  = 3'd0;
    localparam logic [2:0] PCSEL_JUMP = 3'd1;
    localparam logic [2:0] PCSEL_JR   = 3'd2;
    localparam logic [2:0] PCSEL_BR   = 3'd3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        JR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } redirect_state_e;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Next-PC source select, pipeline enables/flushes, jr operand stall and post-branch flush window.
// Define JUMP_DELAY_SLOT_EN to let the delay-slot instruction after j/jal/jr execute.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int JR_MAX_WAIT  = 3,
    parameter int CNT_W        = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Jump_ID,
    input  logic       JumpLink_ID,
    input  logic       JumpReg_ID,
    input  logic       JrSrcBusy,
    input  logic       BranchTaken_EX,
    output logic [2:0] PCSel,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       FlushIFID,
    output logic       FlushIDEX,
    output logic       LinkWrite,
    output logic       JrTimeout
);

`ifdef JUMP_DELAY_SLOT_EN
    localparam logic JUMP_FLUSH = 1'b0;
`else
    localparam logic JUMP_FLUSH = 1'b1;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] JR_MAX_CNT  = CNT_W'(JR_MAX_WAIT);

    redirect_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             jr_timeout_q, jr_timeout_d;

    logic [2:0] pc_sel;
    logic       pc_write, ifid_write, flush_ifid, flush_idex, link_write;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        jr_timeout_d = jr_timeout_q;
        pc_sel       = PCSEL_SEQ;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        link_write   = 1'b0;

        // The branch in EX is older than anything in ID, so it overrides every state.
        if (BranchTaken_EX) begin
            pc_sel     = PCSEL_BR;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_LOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (JumpReg_ID) begin
                        if (JrSrcBusy) begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            flush_idex = 1'b1;
                            cnt_d      = CNT_ONE;
                            state_d    = JR_WAIT;
                        end else begin
                            pc_sel     = PCSEL_JR;
                            flush_ifid = JUMP_FLUSH;
                        end
                    end else if (JumpLink_ID) begin
                        pc_sel     = PCSEL_JUMP;
                        flush_ifid = JUMP_FLUSH;
                        link_write = 1'b1;
                    end else if (Jump_ID) begin
                        pc_sel     = PCSEL_JUMP;
                        flush_ifid = JUMP_FLUSH;
                    end
                end
                JR_WAIT: begin
                    if (JrSrcBusy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        flush_idex = 1'b1;
                        cnt_d      = cnt_inc;
                        if (cnt_inc >= JR_MAX_CNT) begin
                            jr_timeout_d = 1'b1;
                        end
                    end else begin
                        pc_sel     = PCSEL_JR;
                        flush_ifid = JUMP_FLUSH;
                        cnt_d      = '0;
                        state_d    = RUN;
                    end
                end
                FLUSH: begin
                    flush_ifid = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            endcase
        end
    end

    // Reset forces every Mealy output low immediately, not just at the next edge.
    always_comb begin
        PCSel     = Reset ? pc_sel     : PCSEL_SEQ;
        PCWrite   = Reset & pc_write;
        IFIDWrite = Reset & ifid_write;
        FlushIFID = Reset & flush_ifid;
        FlushIDEX = Reset & flush_idex;
        LinkWrite = Reset & link_write;
    end

    assign JrTimeout = jr_timeout_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            jr_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            jr_timeout_q <= jr_timeout_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a per-cycle behavioural model plus hand-computed literal checks.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    localparam int FC = 3;
    localparam int MW = 3;
`ifdef JUMP_DELAY_SLOT_EN
    localparam logic JF = 1'b0;
`else
    localparam logic JF = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic j = 1'b0, jal = 1'b0, jr = 1'b0, busy = 1'b0, br = 1'b0;

    logic [2:0] pc_sel;
    logic       pc_write, ifid_write, flush_ifid, flush_idex, link_write, jr_timeout;

    int vectors = 0;
    int miscompares = 0;

    pc_redirect_ctrl #(
        .FLUSH_CYCLES(FC),
        .JR_MAX_WAIT (MW),
        .CNT_W       (4)
    ) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .Jump_ID       (j),
        .JumpLink_ID   (jal),
        .JumpReg_ID    (jr),
        .JrSrcBusy     (busy),
        .BranchTaken_EX(br),
        .PCSel         (pc_sel),
        .PCWrite       (pc_write),
        .IFIDWrite     (ifid_write),
        .FlushIFID     (flush_ifid),
        .FlushIDEX     (flush_idex),
        .LinkWrite     (link_write),
        .JrTimeout     (jr_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] o(input logic [2:0] sel, input logic pw, input logic iw,
                                     input logic fi, input logic fx, input logic lw, input logic to);
        return {sel, pw, iw, fi, fx, lw, to};
    endfunction

    function automatic logic [8:0] got_vec();
        return {pc_sel, pc_write, ifid_write, flush_ifid, flush_idex, link_write, jr_timeout};
    endfunction

    // Model: wrong-path flush cycles still owed, whether a jr is parked, stalls seen so far.
    int m_flush_left = 0;
    int m_stalls = 0;
    bit m_jr_wait = 1'b0;
    bit m_to = 1'b0;

    function automatic logic [8:0] model_out();
        if (!rst_n)            return '0;
        if (br)                return o(PCSEL_BR, 1, 1, 1, 1, 0, m_to);
        if (m_flush_left > 0)  return o(PCSEL_SEQ, 1, 1, 1, 0, 0, m_to);
        if (m_jr_wait || jr) begin
            if (busy)          return o(PCSEL_SEQ, 0, 0, 0, 1, 0, m_to);
            return o(PCSEL_JR, 1, 1, JF, 0, 0, m_to);
        end
        if (jal)               return o(PCSEL_JUMP, 1, 1, JF, 0, 1, m_to);
        if (j)                 return o(PCSEL_JUMP, 1, 1, JF, 0, 0, m_to);
        return o(PCSEL_SEQ, 1, 1, 0, 0, 0, m_to);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flush_left <= 0;
            m_stalls     <= 0;
            m_jr_wait    <= 1'b0;
            m_to         <= 1'b0;
        end else if (br) begin
            m_flush_left <= FC - 1;
            m_jr_wait    <= 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
        end else if (m_jr_wait) begin
            if (busy) begin
                m_stalls <= m_stalls + 1;
                if (m_stalls + 1 >= MW) m_to <= 1'b1;
            end else begin
                m_jr_wait <= 1'b0;
            end
        end else if (jr && busy) begin
            m_jr_wait <= 1'b1;
            m_stalls  <= 1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_v;
        exp_v = model_out();
        vectors++;
        if (got_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL model-compare t=%0t got=%b expected=%b", $time, got_vec(), exp_v);
        end
    end

    task automatic apply(input logic r, input logic i_j, input logic i_jal, input logic i_jr,
                         input logic i_busy, input logic i_br);
        @(posedge clk);
        #1;
        rst_n = r;
        j     = i_j;
        jal   = i_jal;
        jr    = i_jr;
        busy  = i_busy;
        br    = i_br;
    endtask

    task automatic check(input string name, input logic [8:0] exp_v);
        #2;
        vectors++;
        if (got_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL %s got=%b expected=%b", name, got_vec(), exp_v);
        end
    endtask

    localparam logic [8:0] IDLE = 9'b000_1_1_0_0_0_0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 0, 0, 0); check("reset_hold", '0);
        end
        apply(1, 0, 0, 0, 0, 0); check("post_reset_default", IDLE);

        apply(1, 0, 1, 0, 0, 0); check("jal", o(PCSEL_JUMP, 1, 1, JF, 0, 1, 0));
        apply(1, 0, 0, 0, 0, 0); check("jal_after", IDLE);
        apply(1, 1, 0, 0, 0, 0); check("j", o(PCSEL_JUMP, 1, 1, JF, 0, 0, 0));
        apply(1, 0, 0, 1, 0, 0); check("jr_ready", o(PCSEL_JR, 1, 1, JF, 0, 0, 0));
        apply(1, 1, 1, 1, 0, 0); check("illegal_all_jr_wins", o(PCSEL_JR, 1, 1, JF, 0, 0, 0));
        apply(1, 1, 1, 0, 0, 0); check("illegal_jal_wins", o(PCSEL_JUMP, 1, 1, JF, 0, 1, 0));

        apply(1, 0, 0, 1, 1, 0); check("jr_stall1", o(PCSEL_SEQ, 0, 0, 0, 1, 0, 0));
        apply(1, 0, 0, 1, 1, 0); check("jr_stall2", o(PCSEL_SEQ, 0, 0, 0, 1, 0, 0));
        apply(1, 0, 0, 1, 0, 0); check("jr_release", o(PCSEL_JR, 1, 1, JF, 0, 0, 0));
        apply(1, 0, 0, 0, 0, 0); check("jr_no_timeout", IDLE);

        for (int i = 1; i <= 5; i++) begin
            apply(1, 0, 0, 1, 1, 0);
            check("jr_long_stall", o(PCSEL_SEQ, 0, 0, 0, 1, 0, (i > MW) ? 1'b1 : 1'b0));
        end
        apply(1, 0, 0, 1, 0, 0); check("jr_release_timeout", o(PCSEL_JR, 1, 1, JF, 0, 0, 1));
        apply(1, 0, 0, 0, 0, 0); check("timeout_sticky", o(PCSEL_SEQ, 1, 1, 0, 0, 0, 1));

        apply(1, 1, 0, 0, 0, 1); check("br_over_j", o(PCSEL_BR, 1, 1, 1, 1, 0, 1));
        apply(1, 1, 0, 0, 0, 0); check("flush1_j_ignored", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 1, 0, 0, 0, 0); check("flush2_j_ignored", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 1, 0, 0, 0, 0); check("back_to_run_j", o(PCSEL_JUMP, 1, 1, JF, 0, 0, 1));

        apply(1, 0, 0, 1, 1, 0); check("jr_wait_enter", o(PCSEL_SEQ, 0, 0, 0, 1, 0, 1));
        apply(1, 0, 0, 1, 1, 1); check("br_in_jr_wait", o(PCSEL_BR, 1, 1, 1, 1, 0, 1));
        apply(1, 0, 0, 1, 0, 0); check("jr_squashed1", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 0, 0, 1, 0, 0); check("jr_squashed2", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 0, 0, 0, 0, 0); check("after_squash", o(PCSEL_SEQ, 1, 1, 0, 0, 0, 1));

        apply(1, 0, 0, 0, 0, 1); check("br_a", o(PCSEL_BR, 1, 1, 1, 1, 0, 1));
        apply(1, 0, 1, 0, 0, 0); check("flush_jal_ignored", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 0, 0, 0, 0, 1); check("br_reload", o(PCSEL_BR, 1, 1, 1, 1, 0, 1));
        apply(1, 0, 0, 0, 0, 0); check("reload_flush1", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 0, 0, 0, 0, 0); check("reload_flush2", o(PCSEL_SEQ, 1, 1, 1, 0, 0, 1));
        apply(1, 0, 0, 0, 0, 0); check("reload_done", o(PCSEL_SEQ, 1, 1, 0, 0, 0, 1));

        apply(1, 0, 0, 0, 0, 1); check("br_b", o(PCSEL_BR, 1, 1, 1, 1, 0, 1));
        apply(0, 0, 0, 0, 0, 0); check("reset_mid_flush", '0);
        apply(1, 0, 0, 0, 0, 0); check("after_reset_run", IDLE);

        apply(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Controller for the next-PC select mux in the pipelined datapath.
- Each cycle it decides the PC source: PC+4, j/jal target, jr register, or taken-branch target.
- Drives the pipeline-register flush, PC write and IF/ID write enables.
- Stalls jr until its rs operand is available, and tracks the multi-cycle flush window after a redirect.

Parameters:
- FLUSH_CYCLES, 1: cycles FlushIFID stays asserted after a taken branch (1..4).
- JR_MAX_WAIT, 3: jr stall cycles before JrTimeout is set (1..15).
- CNT_W, 4: width of the internal wait/flush counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Jump_ID  in  1  j decoded in ID.
- JumpLink_ID  in  1  jal decoded in ID.
- JumpReg_ID  in  1  jr decoded in ID.
- JrSrcBusy  in  1  rs of jr not yet forwardable (load in EX/MEM).
- BranchTaken_EX  in  1  branch resolved taken in EX.
- PCSel  out  3  0=PC+4, 1=jump target, 2=jr (rs), 3=branch target.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- FlushIFID  out  1  zero IF/ID on the next edge.
- FlushIDEX  out  1  insert bubble into ID/EX.
- LinkWrite  out  1  write PC+8 to $ra (jal).
- JrTimeout  out  1  sticky; jr stall exceeded JR_MAX_WAIT.

Behaviour:
- Outputs are Mealy (state + inputs, same cycle). Counter, state and JrTimeout are registered.
- While Reset=0: state=RUN, counter=0, JrTimeout=0, PCSel=0, PCWrite=0, IFIDWrite=0, FlushIFID=0, FlushIDEX=0, LinkWrite=0.
- Out of reset, defaults are PCSel=0, PCWrite=1, IFIDWrite=1, all flush/link outputs 0.
- Priority, highest first: BranchTaken_EX > jr > j/jal.
  - The branch is the older instruction, so any ID jump is wrong-path and must be ignored.
- Simultaneous Jump_ID, JumpLink_ID and JumpReg_ID are illegal encodings. Resolve as jr > jal > j.
- RUN state:
  - BranchTaken_EX: PCSel=3, FlushIFID=1, FlushIDEX=1. If FLUSH_CYCLES>1, load counter=FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  - JumpReg_ID & JrSrcBusy: PCWrite=0, IFIDWrite=0, FlushIDEX=1. Load counter=1, go to JR_WAIT.
  - JumpReg_ID & !JrSrcBusy: PCSel=2, FlushIFID=1.
  - JumpLink_ID: PCSel=1, FlushIFID=1, LinkWrite=1.
  - Jump_ID: PCSel=1, FlushIFID=1.
- JR_WAIT state:
  - BranchTaken_EX: same outputs as the RUN branch case; the jr is squashed. Go to FLUSH or RUN per FLUSH_CYCLES.
  - JrSrcBusy=1: PCWrite=0, IFIDWrite=0, FlushIDEX=1. Counter increments, saturating at 2^CNT_W-1. When counter==JR_MAX_WAIT, set JrTimeout. Stay in JR_WAIT (no forced exit).
  - JrSrcBusy=0: PCSel=2, FlushIFID=1, PCWrite=1. Go to RUN.
- FLUSH state:
  - Outputs: PCSel=0, FlushIFID=1. Jump_ID, JumpLink_ID and JumpReg_ID are ignored (wrong-path).
  - Counter decrements each cycle; go to RUN when it reaches 1.
  - A new BranchTaken_EX in FLUSH is treated as in RUN and reloads the counter.
- JrTimeout clears only on reset.
- Reset asserted mid-JR_WAIT or mid-FLUSH returns to RUN immediately (asynchronous); no pending redirect survives.

Optional Feature:
- Macro: JUMP_DELAY_SLOT_EN.
- Defined: j/jal/jr redirects do not assert FlushIFID; the delay-slot instruction in IF/ID executes. LinkWrite still targets PC+8. Branch flush behaviour is unchanged.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Shared package holds:
  - PCSel encoding constants: PCSEL_SEQ=0, PCSEL_JUMP=1, PCSEL_JR=2, PCSEL_BR=3.
  - State encoding: RUN, JR_WAIT, FLUSH.
  - These constants are reused by the next-PC mux and the hazard unit.
- No sub-module. The FSM plus one counter is a single block.

Test Plan:
- Reset held low 3 cycles with Jump_ID=1 -> all outputs 0; after Reset=1 with no inputs -> PCSel=0, PCWrite=1, IFIDWrite=1.
- JumpLink_ID=1 for one cycle -> same cycle PCSel=1, FlushIFID=1, LinkWrite=1; next cycle defaults. With JUMP_DELAY_SLOT_EN -> FlushIFID=0.
- JumpReg_ID=1, JrSrcBusy=1 for 2 cycles then 0 -> 2 cycles of PCWrite=0 and FlushIDEX=1, then PCSel=2 and FlushIFID=1; JrTimeout stays 0.
- JrSrcBusy held 5 cycles with JR_MAX_WAIT=3 -> JrTimeout rises on the 3rd stall cycle and stays 1 until reset.
- BranchTaken_EX and Jump_ID in the same cycle, FLUSH_CYCLES=3 -> PCSel=3, both flushes; then 2 cycles of FlushIFID=1 with Jump_ID ignored; back to RUN.
- BranchTaken_EX during JR_WAIT -> PCSel=3, jr dropped; no PCSel=2 ever issued.
